// File: rtl/apb_m_if.sv
// apb_m_if: APB requester turning a valid/ready command into one APB transfer,
// with a one-cycle response pulse and an optional ACCESS wait-state timeout.
module apb_m_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  state_e            state_q;
  logic [CW-1:0]     wcnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              rsp_valid_q;
  logic              rsp_timeout_q;
  logic              timeout_hit;
  assign timeout_hit = (TIMEOUT > 0) && (wcnt_q == CW'(TIMEOUT));
  // gated by presetn so the block refuses commands while held in reset
  assign cmd_ready   = presetn && (state_q == IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          paddr_q  <= cmd_addr;
          pwrite_q <= cmd_write;
          pwdata_q <= cmd_wdata;
          psel_q   <= 1'b1;
          wcnt_q   <= '0;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: if (pready || timeout_hit) begin
          psel_q        <= 1'b0;
          penable_q     <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_timeout_q <= !pready;
          rsp_rdata_q   <= (pready && !pwrite_q) ? prdata : '0;
          state_q       <= IDLE;
        end else begin
          // saturate so TIMEOUT=0 (no timeout) can never wrap the counter
          wcnt_q <= wcnt_q + CW'(wcnt_q != '1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_m_if.sv
// tb_apb_m_if: directed checks of the APB requester plus a per-cycle protocol monitor.
module tb_apb_m_if;
  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready;
  int          n_chk = 0;
  int          n_pass = 0;
  int          acc;
  apb_m_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  // protocol monitor: ordering and stability of the APB signals every cycle
  logic        prev_ok = 1'b0;
  logic        prev_psel, prev_pen, prev_pwrite;
  logic [31:0] prev_paddr, prev_pwdata;
  always @(negedge pclk) begin
    if (!presetn) prev_ok = 1'b0;
    else begin
      chk("penable_without_psel", 32'(penable & ~psel), 32'd0);
      if (prev_ok && prev_psel && psel) begin
        chk("paddr_stable", paddr, prev_paddr);
        chk("pwrite_stable", 32'(pwrite), 32'(prev_pwrite));
        chk("pwdata_stable", pwdata, prev_pwdata);
      end
      if (prev_ok && prev_psel && !prev_pen) chk("setup_to_access", 32'(psel & penable), 32'd1);
      if (prev_ok && prev_psel && prev_pen && !psel) chk("psel_drop_only_on_rsp", 32'(rsp_valid), 32'd1);
      prev_psel = psel; prev_pen = penable; prev_pwrite = pwrite;
      prev_paddr = paddr; prev_pwdata = pwdata; prev_ok = 1'b1;
    end
  end
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, output int n_acc);
    logic done;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    pready = (waits == 0);
    step();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0BAD_0BAD;
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", 32'(pwrite), 32'(wr));
    if (wr) chk("setup_pwdata", pwdata, wd);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    n_acc = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (penable) begin
        n_acc++;
        pready = (n_acc > waits);
        prdata = rd;
      end else done = 1'b1;
    end
    chk("xfer_bounded", 32'(done), 32'd1);
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b1; cmd_addr = 32'h1234_5678;
    cmd_wdata = 32'h8765_4321; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    step(); step();
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    #2 presetn = 1'b1;
    #1 chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    run_xfer(1'b1, 32'h0, 32'hDEAD_C001, 0, 32'hA5A5_A5A5, acc);
    chk("wr_access_cycles", 32'(acc), 32'd1);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    chk("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    run_xfer(1'b0, 32'h1, 32'h0, 2, 32'hC001_DEAF, acc);
    chk("rd_access_cycles", 32'(acc), 32'd3);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hC001_DEAF);
    chk("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    step();
    chk("idle_paddr_hold", paddr, 32'h1);
    chk("idle_pwrite_hold", 32'(pwrite), 32'd0);
    chk("idle_psel", 32'(psel), 32'd0);
    run_xfer(1'b0, 32'h20, 32'h0, 100, 32'h5555_5555, acc);
    chk("to_access_cycles", 32'(acc), 32'd17);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", 32'(psel), 32'd0);
    step();
    chk("to_rsp_clear", 32'(rsp_valid | rsp_timeout), 32'd0);
    run_xfer(1'b0, 32'h24, 32'h0, 16, 32'h600D_F00D, acc);
    chk("late_access_cycles", 32'(acc), 32'd17);
    chk("late_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("late_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("late_rsp_rdata", rsp_rdata, 32'h600D_F00D);
    step();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1111_2222; pready = 1'b1;
    step();
    chk("b2b_setup1_paddr", paddr, 32'h10);
    cmd_write = 1'b0; cmd_addr = 32'h14; prdata = 32'h1234_5678;
    step();
    chk("b2b_access1_paddr", paddr, 32'h10);
    chk("b2b_access1_pwrite", 32'(pwrite), 32'd1);
    step();
    chk("b2b_rsp1_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_gap_psel", 32'(psel), 32'd0);
    chk("b2b_gap_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_setup2_psel", 32'(psel), 32'd1);
    chk("b2b_setup2_paddr", paddr, 32'h14);
    chk("b2b_setup2_pwrite", 32'(pwrite), 32'd0);
    chk("b2b_setup2_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("b2b_access2_penable", 32'(penable), 32'd1);
    step();
    chk("b2b_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h1234_5678);
    pready = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h7777_8888;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_rst_in_access", 32'(psel & penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_paddr", paddr, 32'd0);
    chk("mid_rst_pwdata", pwdata, 32'd0);
    chk("mid_rst_pwrite", 32'(pwrite), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    pready = 1'b1;
    step();
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    #3 presetn = 1'b1;
    #1 chk("mid_rst_release_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_release_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("mid_rst_no_rsp_after", 32'(rsp_valid), 32'd0);
    run_xfer(1'b1, 32'h44, 32'hCAFE_0001, 0, 32'h0, acc);
    chk("post_rst_xfer_cycles", 32'(acc), 32'd1);
    chk("post_rst_xfer_rsp", 32'(rsp_valid), 32'd1);
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
